// File: rtl/sd_image_arbiter.sv
// sd_image_arbiter
//   Shares the single user_io SD-image block interface among NUM_DISKS virtual
//   drives (floppy 1/2, tape 1/2). Drives raise level read/write requests; the
//   arbiter grants round-robin, holds the bus for the whole transaction and
//   routes ack / buffer strobes back to the granted drive only.
//
//   Optional feature macro: SD_ARB_TIMEOUT_EN
//     When defined, a 24-bit watchdog aborts a REQ/XFER transaction after
//     TIMEOUT_CYCLES cycles and pulses req_err[grant] instead of req_done.
//
// Ports
//   clk_sys      system clock, rising edge
//   reset_n      synchronous active-low reset
//   req_rd/wr    per-drive level requests
//   req_lba      per-drive LBA, drive i at [32i+31:32i]
//   req_din      per-drive write byte, drive i at [8i+7:8i]
//   req_ack      per-drive ack (routed sd_ack)
//   req_buff_wr  per-drive read-data byte strobe
//   req_done     one-cycle completion pulse
//   sd_rd/sd_wr  one-hot requests to user_io
//   sd_lba       muxed LBA to user_io
//   sd_ack       ack from user_io
//   sd_buff_wr   read-data byte strobe from user_io
//   sd_buff_din  muxed write byte to user_io
//   req_err      watchdog abort pulse (SD_ARB_TIMEOUT_EN only)
//   busy         transaction in progress
module sd_image_arbiter #(
    parameter int          NUM_DISKS      = 4,
    parameter int          PTR_W          = (NUM_DISKS > 1) ? $clog2(NUM_DISKS) : 1,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd4_000_000
) (
    input  logic                      clk_sys,
    input  logic                      reset_n,
    input  logic [NUM_DISKS-1:0]      req_rd,
    input  logic [NUM_DISKS-1:0]      req_wr,
    input  logic [32*NUM_DISKS-1:0]   req_lba,
    input  logic [8*NUM_DISKS-1:0]    req_din,
    output logic [NUM_DISKS-1:0]      req_ack,
    output logic [NUM_DISKS-1:0]      req_buff_wr,
    output logic [NUM_DISKS-1:0]      req_done,
    output logic [NUM_DISKS-1:0]      sd_rd,
    output logic [NUM_DISKS-1:0]      sd_wr,
    output logic [31:0]               sd_lba,
    input  logic                      sd_ack,
    input  logic                      sd_buff_wr,
    output logic [7:0]                sd_buff_din,
`ifdef SD_ARB_TIMEOUT_EN
    output logic [NUM_DISKS-1:0]      req_err,
`endif
    output logic                      busy
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_DONE} state_t;

    localparam logic [NUM_DISKS-1:0] ONE   = NUM_DISKS'(1);
    localparam logic [PTR_W:0]       NUM_W = (PTR_W+1)'(NUM_DISKS);
    localparam logic [PTR_W-1:0]     LAST  = PTR_W'(NUM_DISKS - 1);

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]     grant_q, grant_d;
    logic                 op_q, op_d;        // 1 = write
    logic                 rw_on_q, rw_on_d;  // sd_rd/sd_wr strobe active
    logic [31:0]          lba_q, lba_d;

    logic [NUM_DISKS-1:0]   pend;
    logic [2*NUM_DISKS-1:0] rot;
    logic                   sel_found;
    logic [PTR_W:0]         sum;
    logic [PTR_W-1:0]       sel_idx;
    logic [NUM_DISKS-1:0]   sel_oh;
    logic [31:0]            sel_lba;
    logic                   sel_wr;
    logic [PTR_W-1:0]       next_ptr;
    logic [NUM_DISKS-1:0]   grant_oh;

`ifdef SD_ARB_TIMEOUT_EN
    logic [23:0]          cnt_q, cnt_d;
    logic [NUM_DISKS-1:0] err_q, err_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // Round-robin pick: rotate the pending vector so bit 0 is rr_ptr, take
    // the first set bit, then map the offset back to an absolute index.
    always_comb begin
        pend      = req_rd | req_wr;
        rot       = {pend, pend} >> rr_ptr_q;
        sel_found = 1'b0;
        sum       = '0;
        sel_idx   = '0;
        for (int k = 0; k < NUM_DISKS; k++) begin
            if (!sel_found && rot[k]) begin
                sel_found = 1'b1;
                sum       = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
                if (sum >= NUM_W) sum = sum - NUM_W;
                sel_idx   = sum[PTR_W-1:0];
            end
        end
        sel_oh  = ONE << sel_idx;
        sel_wr  = |(req_wr & sel_oh);
        sel_lba = '0;
        for (int i = 0; i < NUM_DISKS; i++)
            if (sel_idx == PTR_W'(i)) sel_lba = req_lba[32*i +: 32];
        grant_oh = ONE << grant_q;
        next_ptr = (grant_q == LAST) ? '0 : grant_q + PTR_W'(1);
    end

    // Next-state process
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        op_d     = op_q;
        rw_on_d  = rw_on_q;
        lba_d    = lba_q;
`ifdef SD_ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
        err_d    = '0;
`endif
        case (state_q)
            S_IDLE: if (sel_found) begin
                state_d = S_REQ;
                grant_d = sel_idx;
                op_d    = sel_wr;   // write wins when both are raised
                rw_on_d = 1'b1;
                lba_d   = sel_lba;
`ifdef SD_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            S_REQ: if (sd_ack) begin
                rw_on_d = 1'b0;
                state_d = S_XFER;
            end
            S_XFER: if (!sd_ack) state_d = S_DONE;
            S_DONE: begin
                rr_ptr_d = next_ptr;
                lba_d    = '0;
                op_d     = 1'b0;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
`ifdef SD_ARB_TIMEOUT_EN
        if (state_q == S_REQ || state_q == S_XFER) begin
            cnt_d = cnt_q + 24'd1;
            if (cnt_q + 24'd1 == TIMEOUT_CYCLES) begin
                rw_on_d  = 1'b0;
                err_d    = grant_oh;
                rr_ptr_d = next_ptr;
                lba_d    = '0;
                op_d     = 1'b0;
                state_d  = S_IDLE;
            end
        end
`endif
    end

    // State register
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            op_q     <= 1'b0;
            rw_on_q  <= 1'b0;
            lba_q    <= '0;
`ifdef SD_ARB_TIMEOUT_EN
            cnt_q    <= '0;
            err_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            op_q     <= op_d;
            rw_on_q  <= rw_on_d;
            lba_q    <= lba_d;
`ifdef SD_ARB_TIMEOUT_EN
            cnt_q    <= cnt_d;
            err_q    <= err_d;
`endif
        end
    end

    // Output process: everything decodes from registered state, so
    // sd_rd/sd_wr/sd_lba change only on clock edges.
    always_comb begin
        busy        = (state_q != S_IDLE);
        sd_rd       = (rw_on_q && !op_q) ? grant_oh : '0;
        sd_wr       = (rw_on_q &&  op_q) ? grant_oh : '0;
        sd_lba      = lba_q;
        req_ack     = (sd_ack && busy) ? grant_oh : '0;
        req_buff_wr = sd_buff_wr ? req_ack : '0;
        req_done    = (state_q == S_DONE) ? grant_oh : '0;
        sd_buff_din = 8'h00;
        if (busy)
            for (int i = 0; i < NUM_DISKS; i++)
                if (grant_q == PTR_W'(i)) sd_buff_din = req_din[8*i +: 8];
    end

`ifdef SD_ARB_TIMEOUT_EN
    assign req_err = err_q;
`endif

endmodule

// File: tb/tb_sd_image_arbiter.sv
module tb_sd_image_arbiter;
    localparam int N = 4;

    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic [N-1:0]    req_rd = '0, req_wr = '0;
    logic [32*N-1:0] req_lba = '0;
    logic [8*N-1:0]  req_din = '0;
    logic            sd_ack = 1'b0, sd_buff_wr = 1'b0;
    logic [N-1:0]    req_ack, req_buff_wr, req_done, sd_rd, sd_wr;
    logic [31:0]     sd_lba;
    logic [7:0]      sd_buff_din;
    logic            busy;
`ifdef SD_ARB_TIMEOUT_EN
    logic [N-1:0]    req_err;
`endif

    sd_image_arbiter #(
        .NUM_DISKS(N)
`ifdef SD_ARB_TIMEOUT_EN
        , .TIMEOUT_CYCLES(24'd100)
`endif
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .req_rd(req_rd), .req_wr(req_wr), .req_lba(req_lba), .req_din(req_din),
        .req_ack(req_ack), .req_buff_wr(req_buff_wr), .req_done(req_done),
        .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_lba(sd_lba),
        .sd_ack(sd_ack), .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din),
`ifdef SD_ARB_TIMEOUT_EN
        .req_err(req_err),
`endif
        .busy(busy)
    );

    typedef struct packed {
        logic [N-1:0] rd;
        logic [N-1:0] wr;
        logic [31:0]  lba;
    } gnt_t;

    gnt_t         gq[$];
    logic [N-1:0] dq[$];
    int           buff_cnt[N];
    int           checks = 0;
    int           errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    task automatic exp_gnt(input logic [N-1:0] rd, input logic [N-1:0] wr, input logic [31:0] lba);
        gq.push_back(gnt_t'{rd, wr, lba});
    endtask

    task automatic drv_edge();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk_sys);
        #1 reset_n = 1'b1;
    endtask

    // user_io model: wait for a grant, ack after wait_n cycles, send strobes,
    // drop ack, then wait for the completion pulse.
    task automatic serve(input int wait_n, input int strobes);
        int t;
        logic [N-1:0] g;
        t = 0;
        while ((sd_rd | sd_wr) == '0 && t < 50) begin @(negedge clk_sys); t++; end
        if ((sd_rd | sd_wr) == '0) begin fail_now("grant_wait"); return; end
        g = sd_rd | sd_wr;
        repeat (wait_n) @(posedge clk_sys);
        #1;
        sd_ack = 1'b1;
        req_rd &= ~g;
        req_wr &= ~g;
        sd_buff_wr = (strobes > 0);
        repeat ((strobes > 0) ? strobes : 1) drv_edge();
        sd_buff_wr = 1'b0;
        sd_ack = 1'b0;
        t = 0;
        do begin @(negedge clk_sys); t++; end while (req_done == '0 && t < 20);
        if (req_done == '0) fail_now("done_wait");
    endtask

    // Monitor: pops expectations on each new grant and each done pulse.
    initial begin
        logic [N-1:0] prev;
        gnt_t e;
        logic [N-1:0] d;
        prev = '0;
        forever begin
            @(negedge clk_sys);
            for (int i = 0; i < N; i++) buff_cnt[i] += int'(req_buff_wr[i]);
            if ((sd_rd | sd_wr) != '0 && prev == '0) begin
                if (gq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_grant: got rd=%b wr=%b expected none", sd_rd, sd_wr);
                end else begin
                    e = gq.pop_front();
                    chk("grant_rd", 64'(sd_rd), 64'(e.rd));
                    chk("grant_wr", 64'(sd_wr), 64'(e.wr));
                    chk("grant_lba", 64'(sd_lba), 64'(e.lba));
                end
            end
            prev = sd_rd | sd_wr;
            if (req_done != '0) begin
                if (dq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got %b expected none", req_done);
                end else begin
                    d = dq.pop_front();
                    chk("done", 64'(req_done), 64'(d));
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        int others;
        for (int i = 0; i < N; i++) begin
            req_lba[32*i +: 32] = 32'h100 + 32'(i);
            req_din[8*i +: 8]   = 8'h11 * 8'(i + 1);
            buff_cnt[i] = 0;
        end
        do_reset();

        // reset state
        @(negedge clk_sys);
        chk("rst_sd_rd", 64'(sd_rd), 0);
        chk("rst_sd_wr", 64'(sd_wr), 0);
        chk("rst_sd_lba", 64'(sd_lba), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(req_done), 0);
        chk("rst_din", 64'(sd_buff_din), 0);

        // drive 2 read, 512 strobes
        req_lba[64 +: 32] = 32'h0000_0123;
        exp_gnt(4'b0100, 4'b0000, 32'h123);
        dq.push_back(4'b0100);
        drv_edge();
        req_rd[2] = 1'b1;
        @(negedge clk_sys);
        chk("rd_latency0", 64'(sd_rd), 0);
        @(negedge clk_sys);
        chk("rd_latency1", 64'(sd_rd), 64'(4'b0100));
        serve(3, 512);
        @(negedge clk_sys);
        chk("busy_after_done", 64'(busy), 0);
        chk("buff_cnt2", 64'(buff_cnt[2]), 512);
        others = buff_cnt[0] + buff_cnt[1] + buff_cnt[3];
        chk("buff_cnt_others", 64'(others), 0);
        req_lba[64 +: 32] = 32'h102;

        // round robin from reset, drive 0 re-requests during grant 3
        do_reset();
        exp_gnt(4'b0001, 4'b0, 32'h100);
        exp_gnt(4'b0010, 4'b0, 32'h101);
        exp_gnt(4'b0100, 4'b0, 32'h102);
        exp_gnt(4'b1000, 4'b0, 32'h103);
        exp_gnt(4'b0001, 4'b0, 32'h100);
        dq.push_back(4'b0001); dq.push_back(4'b0010); dq.push_back(4'b0100);
        dq.push_back(4'b1000); dq.push_back(4'b0001);
        req_rd = 4'b1111;
        serve(1, 0);
        serve(1, 0);
        serve(1, 0);
        drv_edge();
        req_rd[0] = 1'b1;
        serve(1, 0);
        serve(1, 0);

        // drive 1 read+write -> write wins, din muxed
        @(negedge clk_sys);
        chk("din_idle", 64'(sd_buff_din), 0);
        req_din[15:8] = 8'hA5;
        exp_gnt(4'b0000, 4'b0010, 32'h101);
        dq.push_back(4'b0010);
        drv_edge();
        req_rd[1] = 1'b1;
        req_wr[1] = 1'b1;
        @(negedge clk_sys);
        @(negedge clk_sys);
        chk("din_busy", 64'(sd_buff_din), 64'(8'hA5));
        chk("busy_in_req", 64'(busy), 1);
        serve(2, 0);

        // reset while in XFER: no done, rr_ptr back to 0
        exp_gnt(4'b0100, 4'b0, 32'h102);
        drv_edge();
        req_rd[2] = 1'b1;
        @(negedge clk_sys);
        @(negedge clk_sys);
        drv_edge();
        sd_ack = 1'b1;
        req_rd[2] = 1'b0;
        drv_edge();
        reset_n = 1'b0;
        drv_edge();
        reset_n = 1'b1;
        sd_ack = 1'b0;
        @(negedge clk_sys);
        chk("xrst_sd_rd", 64'(sd_rd), 0);
        chk("xrst_sd_wr", 64'(sd_wr), 0);
        chk("xrst_busy", 64'(busy), 0);
        chk("xrst_done", 64'(req_done), 0);
        drv_edge();
        sd_ack = 1'b1;
        @(negedge clk_sys);
        chk("stray_ack", 64'(req_ack), 0);
        chk("stray_busy", 64'(busy), 0);
        drv_edge();
        sd_ack = 1'b0;

        // drives 0 and 3 pending: rr_ptr=0 picks 0 first; drive 3 then drops early
        exp_gnt(4'b0001, 4'b0, 32'h100);
        exp_gnt(4'b1000, 4'b0, 32'h103);
        dq.push_back(4'b0001);
        dq.push_back(4'b1000);
        req_rd = 4'b1001;
        serve(1, 0);
        t = 0;
        while (sd_rd[3] !== 1'b1 && t < 20) begin @(negedge clk_sys); t++; end
        if (sd_rd[3] !== 1'b1) fail_now("grant3_wait");
        drv_edge();
        req_rd[3] = 1'b0;
        serve(2, 0);

`ifdef SD_ARB_TIMEOUT_EN
        // watchdog: never ack drive 0, drive 1 granted after the abort
        exp_gnt(4'b0001, 4'b0, 32'h100);
        exp_gnt(4'b0010, 4'b0, 32'h101);
        dq.push_back(4'b0010);
        req_wr[1] = 1'b0;
        drv_edge();
        req_rd = 4'b0011;
        t = 0;
        while (sd_rd == '0 && t < 20) begin @(negedge clk_sys); t++; end
        t = 0;
        while (req_err == '0 && t < 300) begin @(negedge clk_sys); t++; end
        chk("err_vec", 64'(req_err), 64'(4'b0001));
        chk("err_cycles", 64'(t), 100);
        chk("err_sd_rd", 64'(sd_rd), 0);
        drv_edge();
        req_rd[0] = 1'b0;
        @(negedge clk_sys);
        chk("err_pulse_len", 64'(req_err), 0);
        serve(1, 0);
`endif

        repeat (4) @(negedge clk_sys);
        chk("grant_queue_empty", 64'(gq.size()), 0);
        chk("done_queue_empty", 64'(dq.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
